// File: rtl/skinny_sbox_layer_seq.sv
// Serialises a 64-bit two-share SKINNY state nibble-by-nibble through an external masked S-box.
// Define FRESH_LFSR_EN to source sb_fresh from an internal 64-bit LFSR seeded by fresh_i.
module skinny_sbox_layer_seq #(
  parameter int SBOX_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] state_s0_i,
  input  logic [63:0] state_s1_i,
  input  logic [63:0] fresh_i,
  output logic [3:0]  sb_x_s0,
  output logic [3:0]  sb_x_s1,
  output logic [63:0] sb_fresh,
  input  logic [3:0]  sb_y_s0,
  input  logic [3:0]  sb_y_s1,
  output logic [63:0] state_s0_o,
  output logic [63:0] state_s1_o,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          st;
  logic [3:0]          cnt;
  logic [2:0]          dcnt;
  logic [63:0]         sh0;
  logic [63:0]         sh1;
  logic                acc;
  logic [SBOX_LAT-1:0] tag_v;
  logic [3:0]          tag_idx [SBOX_LAT];
  logic [5:0]          cap_pos;

  assign acc     = (st == IDLE) && start;
  assign busy    = (st != IDLE);
  assign done    = (st == DONE);
  assign sb_x_s0 = (st == ISSUE) ? sh0[3:0] : 4'h0;
  assign sb_x_s1 = (st == ISSUE) ? sh1[3:0] : 4'h0;
  assign cap_pos = {tag_idx[SBOX_LAT-1], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      cnt  <= '0;
      dcnt <= '0;
      sh0  <= '0;
      sh1  <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (start) begin
            st  <= ISSUE;
            cnt <= '0;
            sh0 <= state_s0_i;
            sh1 <= state_s1_i;
          end
        end
        ISSUE: begin
          sh0 <= {4'h0, sh0[63:4]};
          sh1 <= {4'h0, sh1[63:4]};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            st   <= DRAIN;
            dcnt <= '0;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 3'd1;
          if (dcnt == 3'(SBOX_LAT - 1))
            st <= DONE;
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  // Each tag follows one issued nibble through the S-box pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < SBOX_LAT; i++)
        tag_idx[i] <= '0;
    end else begin
      tag_v[0]   <= (st == ISSUE);
      tag_idx[0] <= cnt;
      for (int i = 1; i < SBOX_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_s0_o <= '0;
      state_s1_o <= '0;
    end else if (acc) begin
      state_s0_o <= '0;
      state_s1_o <= '0;
    end else if (tag_v[SBOX_LAT-1]) begin
      state_s0_o[cap_pos +: 4] <= sb_y_s0;
      state_s1_o[cap_pos +: 4] <= sb_y_s1;
    end
  end

`ifdef FRESH_LFSR_EN
  logic [63:0] lfsr;
  logic        fb;

  assign fb       = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];
  assign sb_fresh = lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= 64'h1;
    else if (acc)
      lfsr <= (fresh_i == 64'h0) ? 64'h1 : fresh_i;
    else if (st == ISSUE || st == DRAIN)
      lfsr <= {lfsr[62:0], fb};
  end
`else
  assign sb_fresh = fresh_i;
`endif

endmodule

// File: tb/tb_skinny_sbox_layer_seq.sv
// Bench for skinny_sbox_layer_seq: three latencies side by side, each with a masked model S-box.
// Results are checked against a nibble-table SKINNY-64 substitution layer on recombined shares.
module tb_skinny_sbox_layer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] s0_i, s1_i, fresh_i;

  logic [3:0]  x0 [3];
  logic [3:0]  x1 [3];
  logic [3:0]  y0 [3];
  logic [3:0]  y1 [3];
  logic [63:0] fr [3];
  logic [63:0] o0 [3];
  logic [63:0] o1 [3];
  logic        bsy [3];
  logic        dn [3];
  logic [7:0]  pipe [3][4];
  int          lat [3] = '{2, 1, 4};

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] keep0, keep1;

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input logic [3:0] v);
    logic [63:0] t;
    t = 64'hF7E4D583B2A1096C;
    return t[{v, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] slayer(input logic [63:0] x);
    logic [63:0] r;
    for (int k = 0; k < 16; k++)
      r[4*k +: 4] = sbox(x[4*k +: 4]);
    return r;
  endfunction

  skinny_sbox_layer_seq #(.SBOX_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .state_s0_i(s0_i), .state_s1_i(s1_i), .fresh_i(fresh_i),
    .sb_x_s0(x0[0]), .sb_x_s1(x1[0]), .sb_fresh(fr[0]),
    .sb_y_s0(y0[0]), .sb_y_s1(y1[0]),
    .state_s0_o(o0[0]), .state_s1_o(o1[0]),
    .busy(bsy[0]), .done(dn[0])
  );

  skinny_sbox_layer_seq #(.SBOX_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .state_s0_i(s0_i), .state_s1_i(s1_i), .fresh_i(fresh_i),
    .sb_x_s0(x0[1]), .sb_x_s1(x1[1]), .sb_fresh(fr[1]),
    .sb_y_s0(y0[1]), .sb_y_s1(y1[1]),
    .state_s0_o(o0[1]), .state_s1_o(o1[1]),
    .busy(bsy[1]), .done(dn[1])
  );

  skinny_sbox_layer_seq #(.SBOX_LAT(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .state_s0_i(s0_i), .state_s1_i(s1_i), .fresh_i(fresh_i),
    .sb_x_s0(x0[2]), .sb_x_s1(x1[2]), .sb_fresh(fr[2]),
    .sb_y_s0(y0[2]), .sb_y_s1(y1[2]),
    .state_s0_o(o0[2]), .state_s1_o(o1[2]),
    .busy(bsy[2]), .done(dn[2])
  );

  // Masked S-box model: remask output with one fresh nibble, fixed latency.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 3; j > 0; j--)
        pipe[i][j] <= pipe[i][j-1];
      pipe[i][0] <= {sbox(x0[i] ^ x1[i]) ^ fr[i][3:0], fr[i][3:0]};
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      y0[i] = pipe[i][lat[i]-1][7:4];
      y1[i] = pipe[i][lat[i]-1][3:0];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [63:0] obs,
                        input logic [63:0] other);
    n_cmp++;
    assert (obs !== other) else begin
      n_bad++;
      $error("FAIL %s: observed %h must differ from %h", tag, obs, other);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy"}, {63'h0, bsy[i]}, 64'h0);
      chk({tag, "_done"}, {63'h0, dn[i]}, 64'h0);
      chk({tag, "_o0"}, o0[i], 64'h0);
      chk({tag, "_o1"}, o1[i], 64'h0);
      chk({tag, "_x"}, {56'h0, x0[i], x1[i]}, 64'h0);
    end
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] seed, input bit hold,
                     input int abort_at);
    logic [63:0] exp, prev;
    int dc [3];
    int nd [3];
    int ncyc;
    exp  = slayer(a ^ b);
    prev = '0;
    dc   = '{0, 0, 0};
    nd   = '{0, 0, 0};
    ncyc = hold ? 50 : 26;
    s0_i = a;
    s1_i = b;
    fresh_i = seed;
    start = 1'b1;
    @(posedge clk);
    if (!hold) begin
      #1;
      start = 1'b0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin
          nd[i]++;
          if (dc[i] == 0) dc[i] = c;
          chk("done_result", o0[i] ^ o1[i], exp);
        end
      end
      if (c <= 16) begin
        chk("x_s0", {60'h0, x0[0]}, {60'h0, a[4*(c-1) +: 4]});
        chk("x_s1", {60'h0, x1[0]}, {60'h0, b[4*(c-1) +: 4]});
      end else if (c <= 17 + lat[0]) begin
        chk("x_quiet", {56'h0, x0[0], x1[0]}, 64'h0);
      end
      if (c <= 17 + lat[0])
        chk("busy_run", {63'h0, bsy[0]}, 64'h1);
      else if (c == 18 + lat[0])
        chk("busy_idle", {63'h0, bsy[0]}, 64'h0);
      if (hold && c == 19 + lat[0])
        chk("busy_restart", {63'h0, bsy[0]}, 64'h1);
`ifdef FRESH_LFSR_EN
      if (c == 1)
        chk("fresh_seed", fr[0], (seed == 64'h0) ? 64'h1 : seed);
      else if (c <= 16)
        chk_ne("fresh_step", fr[0], prev);
`else
      if (c <= 17 + lat[0])
        chk("fresh_pass", fr[0], fresh_i);
`endif
      prev = fr[0];
      fresh_i = {$urandom(), $urandom()};
      if (hold && c == 23)
        start = 1'b0;
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk("done_count", 64'(nd[i]), hold ? 64'd2 : 64'd1);
      chk("done_cycle", 64'(dc[i]), 64'(17 + lat[i]));
      chk("final_result", o0[i] ^ o1[i], exp);
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    rst_n = 1'b1;
    start = 1'b0;
    s0_i = '0;
    s1_i = '0;
    fresh_i = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    run(64'h0123456789ABCDEF, 64'h0, 64'h0, 1'b0, 0);
    chk("known_answer", o0[0] ^ o1[0], 64'hC6901A2B385D4E7F);
    keep0 = o0[0];
    keep1 = o1[0];

    run(64'h0123456789ABCDEF ^ 64'hA5A5A5A5A5A5A5A5,
        64'hA5A5A5A5A5A5A5A5, {$urandom(), $urandom()}, 1'b0, 0);
    chk("masked_answer", o0[0] ^ o1[0], 64'hC6901A2B385D4E7F);
    chk_ne("masked_share0", o0[0], keep0);
    chk_ne("masked_share1", o1[0], keep1);

    run({$urandom(), $urandom()}, {$urandom(), $urandom()},
        {$urandom(), $urandom()}, 1'b1, 0);

    run({$urandom(), $urandom()}, {$urandom(), $urandom()},
        {$urandom(), $urandom()}, 1'b0, 9);
    run(64'hFFFFFFFFFFFFFFFF, 64'h0, {$urandom(), $urandom()}, 1'b0, 0);
    chk("all_ones", o0[0] ^ o1[0], 64'hFFFFFFFFFFFFFFFF);

    for (int r = 0; r < 3; r++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      run(ra, rb, {$urandom(), $urandom()}, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/skinny_sbox_layer_seq.md
SKINNY_SBOX_LAYER_SEQ -- requirements
Module: skinny_sbox_layer_seq

Interface
REQ-001 SHALL have parameter: SBOX_LAT, 2, S-box input-to-output latency in clock cycles, legal range 1..4.
REQ-002 SHALL have ports: clk  input  1  clock, all flops rising-edge.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: start  input  1  request to process one 64-bit masked state.
REQ-005 SHALL have ports: state_s0_i / state_s1_i  input  64 each  input state shares; nibble k = bits 4k+3:4k.
REQ-006 SHALL have ports: fresh_i  input  64  external randomness (seed in LFSR build, see Configuration).
REQ-007 SHALL have ports: sb_x_s0 / sb_x_s1  output  4 each  nibble shares to the masked S-box.
REQ-008 SHALL have ports: sb_fresh  output  64  randomness to the S-box Fresh bus.
REQ-009 SHALL have ports: sb_y_s0 / sb_y_s1  input  4 each  S-box output shares.
REQ-010 SHALL have ports: state_s0_o / state_s1_o  output  64 each  substituted state shares.
REQ-011 SHALL have ports: busy  output  1  high while not IDLE; done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE; busy = (state != IDLE).
REQ-013 SHALL in IDLE, on start=1 at edge E0, load both input shares, clear state_s*_o to 0, enter ISSUE with issue counter 0.
REQ-014 SHALL ignore start whenever busy=1; no queuing.
REQ-015 SHALL in ISSUE drive nibble k of the loaded shares on sb_x_s0/sb_x_s1 during cycle k+1 after E0, k=0..15, ascending, from registers (no combinational path from state_s*_i).
REQ-016 SHALL enter DRAIN after nibble 15; stay SBOX_LAT cycles; then DONE for one cycle; then IDLE.
REQ-017 SHALL capture sb_y_s0/sb_y_s1 into nibble k of state_s*_o at the end of cycle k+1+SBOX_LAT (valid-tag shift register of depth SBOX_LAT tracks in-flight nibbles and indices).
REQ-018 SHALL assert done for exactly one cycle, high in the cycle after edge E0+16+SBOX_LAT (cycle 19 after E0 for default); all 16 nibbles valid then.
REQ-019 SHALL hold state_s*_o stable after done until the next accepted start.
REQ-020 SHALL drive sb_x_s* to 0 outside ISSUE.
REQ-021 SHALL never combine shares (no XOR of s0 with s1 anywhere in the block).
REQ-022 SHALL present a new sb_fresh value every ISSUE cycle; sb_fresh is don't-care outside ISSUE/DRAIN.

Reset
REQ-023 SHALL on rst_n=0 immediately force IDLE, busy=0, done=0, state_s*_o=0, sb_x_s*=0, counters and valid tags 0, independent of clk.
REQ-024 SHALL on reset mid-operation discard the in-flight state; S-box results arriving after reset release SHALL be ignored.
REQ-025 SHALL accept start on the first edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with FRESH_LFSR_EN defined, generate sb_fresh from an internal 64-bit maximal-length LFSR (taps 64,63,61,60), loaded from fresh_i at start acceptance (all-zero seed replaced by 64'h1) and stepped once per cycle in ISSUE and DRAIN.
REQ-027 SHALL, without FRESH_LFSR_EN, drive sb_fresh = fresh_i combinationally, no LFSR flops instantiated.

Verification
REQ-028 SHALL cover: bench S-box (Skinny-64, SBOX_LAT=2), state_s0_i=0x0123456789ABCDEF, state_s1_i=0, start -> done in cycle 19 after E0, state_s0_o^state_s1_o=0xC6901A2B385D4E7F.
REQ-029 SHALL cover: same plaintext masked with state_s1_i=0xA5A5A5A5A5A5A5A5, state_s0_i=plaintext^mask -> recombined output 0xC6901A2B385D4E7F, shares differ from unmasked run.
REQ-030 SHALL cover: start held high throughout a run -> exactly one done, second run accepted on first edge with busy=0.
REQ-031 SHALL cover: rst_n pulsed low in cycle 9 of a run -> outputs 0, busy=0 at once; subsequent run with state 0xFFFFFFFFFFFFFFFF, mask 0 yields 0xFFFFFFFFFFFFFFFF.
REQ-032 SHALL cover: SBOX_LAT=1 and 4 with matching model S-box -> done in cycle 18 resp. 21, results as REQ-028.
REQ-033 SHALL cover: FRESH_LFSR_EN defined, fresh_i=0 -> sb_fresh starts 64'h1, changes every ISSUE cycle; undefined -> sb_fresh tracks fresh_i each cycle.
